// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants. The timing generator and the downstream
// pattern stage both import these so their view of the screen cannot drift.
package vga_timing_pkg;

  localparam int COORD_W  = 10;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int H_RES    = H_ACTIVE;
  localparam int V_RES    = V_ACTIVE;

  // 640x480@60 uses negative sync pulses on both axes.
  localparam int SYNC_NEG = 1;

  typedef logic [COORD_W-1:0] coord_t;

  function automatic logic sync_level(input logic active, input int sync_neg);
    return (sync_neg != 0) ? ~active : active;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster timing generator: free-running x/y counters advanced by a pixel
// enable, with all decoded outputs registered in a single aligned stage.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int H_FP     = vga_timing_pkg::H_FP,
  parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int H_BP     = vga_timing_pkg::H_BP,
  parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int V_FP     = vga_timing_pkg::V_FP,
  parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int V_BP     = vga_timing_pkg::V_BP,
  parameter int SYNC_NEG = vga_timing_pkg::SYNC_NEG
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_pix_en,
  output logic               o_hsync,
  output logic               o_vsync,
  output logic               o_de,
  output logic [COORD_W-1:0] o_x,
  output logic [COORD_W-1:0] o_y,
  output logic               o_line,
  output logic               o_frame
);

  localparam int L_H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int L_V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int L_HS_START = H_ACTIVE + H_FP;
  localparam int L_HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int L_VS_START = V_ACTIVE + V_FP;
  localparam int L_VS_END   = V_ACTIVE + V_FP + V_SYNC;

  generate
    if ((L_H_TOTAL > 1024) || (L_V_TOTAL > 1024)) begin : g_bad_totals
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end
  endgenerate

  localparam coord_t L_H_LAST = coord_t'(L_H_TOTAL - 1);
  localparam coord_t L_V_LAST = coord_t'(L_V_TOTAL - 1);
  localparam logic   L_SYNC_IDLE = sync_level(1'b0, SYNC_NEG);

  coord_t r_cx, r_cy;
  coord_t r_x, r_y;
  logic   r_hsync, r_vsync, r_de, r_line, r_frame;

  logic [31:0] w_cx32, w_cy32;
  logic        w_hs_act, w_vs_act, w_de, w_col0, w_top_blank;

  assign w_cx32      = 32'(r_cx);
  assign w_cy32      = 32'(r_cy);
  assign w_hs_act    = (w_cx32 >= L_HS_START) && (w_cx32 < L_HS_END);
  assign w_vs_act    = (w_cy32 >= L_VS_START) && (w_cy32 < L_VS_END);
  assign w_de        = (w_cx32 < H_ACTIVE) && (w_cy32 < V_ACTIVE);
  assign w_col0      = (r_cx == '0);
  assign w_top_blank = (w_cy32 == V_ACTIVE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cx <= '0;
      r_cy <= '0;
    end else if (i_pix_en) begin
      if (r_cx == L_H_LAST) begin
        r_cx <= '0;
        r_cy <= (r_cy == L_V_LAST) ? '0 : r_cy + coord_t'(1);
      end else begin
        r_cx <= r_cx + coord_t'(1);
      end
    end
  end

  // Output stage: decode of the pre-increment counters, one clk behind them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x     <= '0;
      r_y     <= '0;
      r_de    <= 1'b0;
      r_hsync <= L_SYNC_IDLE;
      r_vsync <= L_SYNC_IDLE;
    end else if (i_pix_en) begin
      r_x     <= r_cx;
      r_y     <= r_cy;
      r_de    <= w_de;
      r_hsync <= sync_level(w_hs_act, SYNC_NEG);
      r_vsync <= sync_level(w_vs_act, SYNC_NEG);
    end
  end

  // Strobes are re-evaluated every clk so they never outlast a single cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_line  <= 1'b0;
      r_frame <= 1'b0;
    end else begin
      r_line  <= i_pix_en && w_col0;
      r_frame <= i_pix_en && w_col0 && w_top_blank;
    end
  end

  assign o_x     = r_x;
  assign o_y     = r_y;
  assign o_de    = r_de;
  assign o_hsync = r_hsync;
  assign o_vsync = r_vsync;
  assign o_line  = r_line;
  assign o_frame = r_frame;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size negative-sync instance and a tiny
// positive-sync instance, both checked every clk against a pixel-index model.
module tb_vga_timing_gen;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb, neg;
  } tim_t;

  typedef struct {
    logic [9:0] x, y;
    logic       de, hs, vs, ln, fr;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  logic pix_en;

  logic       hs_a, vs_a, de_a, ln_a, fr_a;
  logic [9:0] x_a, y_a;
  logic       hs_b, vs_b, de_b, ln_b, fr_b;
  logic [9:0] x_b, y_b;

  int errors = 0;
  int checks = 0;

  tim_t tA, tB;
  int   pA, pB;
  exp_t eA, eB;

  always #5 clk = ~clk;

  vga_timing_gen u_dut (
    .clk(clk), .reset_n(reset_n), .i_pix_en(pix_en),
    .o_hsync(hs_a), .o_vsync(vs_a), .o_de(de_a),
    .o_x(x_a), .o_y(y_a), .o_line(ln_a), .o_frame(fr_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(1),
    .SYNC_NEG(0)
  ) u_small (
    .clk(clk), .reset_n(reset_n), .i_pix_en(pix_en),
    .o_hsync(hs_b), .o_vsync(vs_b), .o_de(de_b),
    .o_x(x_b), .o_y(y_b), .o_line(ln_b), .o_frame(fr_b)
  );

  function automatic int htot(tim_t t);
    return t.ha + t.hf + t.hs + t.hb;
  endfunction

  function automatic int frame_len(tim_t t);
    return htot(t) * (t.va + t.vf + t.vs + t.vb);
  endfunction

  // Expected outputs for the p-th pixel of a frame, counted in raster order.
  function automatic exp_t decode(tim_t t, int p);
    exp_t e;
    int x, y;
    logic hact, vact;
    x = p % htot(t);
    y = p / htot(t);
    hact = (x >= t.ha + t.hf) && (x < t.ha + t.hf + t.hs);
    vact = (y >= t.va + t.vf) && (y < t.va + t.vf + t.vs);
    e.x  = 10'(x);
    e.y  = 10'(y);
    e.de = (x < t.ha) && (y < t.va);
    e.hs = (t.neg != 0) ? !hact : hact;
    e.vs = (t.neg != 0) ? !vact : vact;
    e.ln = (x == 0);
    e.fr = (x == 0) && (y == t.va);
    return e;
  endfunction

  function automatic exp_t reset_exp(tim_t t);
    exp_t e;
    e.x  = '0;
    e.y  = '0;
    e.de = 1'b0;
    e.hs = (t.neg != 0);
    e.vs = (t.neg != 0);
    e.ln = 1'b0;
    e.fr = 1'b0;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_both(input string ph);
    chk({ph, ":A.x"},  x_a,  eA.x);
    chk({ph, ":A.y"},  y_a,  eA.y);
    chk({ph, ":A.de"}, {9'd0, de_a}, {9'd0, eA.de});
    chk({ph, ":A.hs"}, {9'd0, hs_a}, {9'd0, eA.hs});
    chk({ph, ":A.vs"}, {9'd0, vs_a}, {9'd0, eA.vs});
    chk({ph, ":A.ln"}, {9'd0, ln_a}, {9'd0, eA.ln});
    chk({ph, ":A.fr"}, {9'd0, fr_a}, {9'd0, eA.fr});
    chk({ph, ":B.x"},  x_b,  eB.x);
    chk({ph, ":B.y"},  y_b,  eB.y);
    chk({ph, ":B.de"}, {9'd0, de_b}, {9'd0, eB.de});
    chk({ph, ":B.hs"}, {9'd0, hs_b}, {9'd0, eB.hs});
    chk({ph, ":B.vs"}, {9'd0, vs_b}, {9'd0, eB.vs});
    chk({ph, ":B.ln"}, {9'd0, ln_b}, {9'd0, eB.ln});
    chk({ph, ":B.fr"}, {9'd0, fr_b}, {9'd0, eB.fr});
  endtask

  task automatic model_reset();
    pA = 0;
    pB = 0;
    eA = reset_exp(tA);
    eB = reset_exp(tB);
  endtask

  // One clk with the given enable; model advances, then outputs are checked.
  task automatic step(input logic en, input string ph);
    pix_en = en;
    @(posedge clk);
    if (en) begin
      eA = decode(tA, pA);
      eB = decode(tB, pB);
      pA = (pA + 1) % frame_len(tA);
      pB = (pB + 1) % frame_len(tB);
    end else begin
      eA.ln = 1'b0; eA.fr = 1'b0;
      eB.ln = 1'b0; eB.fr = 1'b0;
    end
    #1;
    chk_both(ph);
  endtask

  initial begin
    tA = '{640, 16, 96, 48, 480, 10, 2, 33, 1};
    tB = '{8, 2, 3, 2, 6, 2, 2, 1, 0};

    reset_n = 1'b0;
    pix_en  = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk_both("reset_hold");
    end

    reset_n = 1'b1;
    step(1'b1, "first_pixel");

    for (int i = 0; i < 2500; i++) step(1'b1, "tied_en");
    for (int i = 0; i < 3400; i++) step(1'(i % 2), "half_rate");
    for (int i = 0; i < 3000; i++) step(1'($urandom_range(0, 1)), "rand_en");

    // Walk the big instance to column 700 (inside hsync), then reset mid-line.
    for (int g = 0; g < 2000 && eA.x != 10'd700; g++) step(1'b1, "seek700");
    chk("seek_x700", x_a, 10'd700);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk_both("async_reset");
    for (int i = 0; i < 2; i++) begin
      pix_en = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      chk_both("reset_hold2");
    end
    reset_n = 1'b1;
    step(1'b1, "restart_pixel");

    for (int i = 0; i < 1500; i++) step(1'($urandom_range(0, 3) != 0), "rand_tail");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
